// File: rtl/tour_seq.sv
// Knight's-tour sequencer: kicks the solver, turns each stored move into a vertical
// and a horizontal motion command, and arbitrates the command port. Optional: TOUR_SEQ_POS_EN.
module tour_seq #(
    parameter int NUM_MOVES = 24,
    parameter int SOLVE_TO  = 2**22,
    parameter int TO_W      = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    input  logic [2:0]  x_start,
    input  logic [2:0]  y_start,
    output logic        tour_go,
    input  logic        tour_done,
    output logic [4:0]  indx,
    input  logic [7:0]  move,
    input  logic [15:0] ext_cmd,
    input  logic        ext_vld,
    output logic        ext_rdy,
    output logic [15:0] cmd,
    output logic        cmd_vld,
    input  logic        cmd_rdy,
    input  logic        cmd_cmplt,
    output logic        busy,
    output logic        tour_cmplt,
`ifdef TOUR_SEQ_POS_EN
    output logic [2:0]  cur_x,
    output logic [2:0]  cur_y,
`endif
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_SOLVE, S_FETCH, S_LEG_V, S_WAIT_V, S_LEG_H, S_WAIT_H
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [4:0]        indx_q, indx_d;
    logic [7:0]        mv_q, mv_d;
    logic signed [2:0] dx, dy;
    logic [2:0]        adx, ady;
    logic [15:0]       vcmd, hcmd;
    logic              pos_bad_v, pos_bad_h;

    always_comb begin
        dx = 3'sd0;
        dy = 3'sd0;
        case (mv_q)
            8'h01: begin dx = -3'sd1; dy =  3'sd2; end
            8'h02: begin dx =  3'sd1; dy =  3'sd2; end
            8'h04: begin dx = -3'sd2; dy =  3'sd1; end
            8'h08: begin dx = -3'sd2; dy = -3'sd1; end
            8'h10: begin dx = -3'sd1; dy = -3'sd2; end
            8'h20: begin dx =  3'sd1; dy = -3'sd2; end
            8'h40: begin dx =  3'sd2; dy = -3'sd1; end
            8'h80: begin dx =  3'sd2; dy =  3'sd1; end
            default: ;
        endcase
    end

    assign adx  = dx[2] ? 3'(-dx) : 3'(dx);
    assign ady  = dy[2] ? 3'(-dy) : 3'(dy);
    assign vcmd = {4'h2, (dy[2] ? 8'h7F : 8'h00), 1'b0, ady};
    assign hcmd = {4'h3, (dx[2] ? 8'h3F : 8'hBF), 1'b0, adx};

`ifdef TOUR_SEQ_POS_EN
    logic [2:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d, nx, ny;

    // 3-bit wrap: an off-board step lands on 5..7, so a single compare catches both edges
    assign nx        = cur_x_q + dx;
    assign ny        = cur_y_q + dy;
    assign pos_bad_v = (ny > 3'd4);
    assign pos_bad_h = (nx > 3'd4);

    always_comb begin
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (state_q == S_START) begin
            cur_x_d = x_start;
            cur_y_d = y_start;
        end else if (state_q == S_WAIT_V && cmd_cmplt && !pos_bad_v) begin
            cur_y_d = ny;
        end else if (state_q == S_WAIT_H && cmd_cmplt && !pos_bad_h) begin
            cur_x_d = nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_x_q <= '0;
            cur_y_q <= '0;
        end else begin
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
        end
    end

    assign cur_x = cur_x_q;
    assign cur_y = cur_y_q;
`else
    logic unused_start;
    assign unused_start = ^{x_start, y_start};
    assign pos_bad_v    = 1'b0;
    assign pos_bad_h    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        indx_d     = indx_q;
        mv_d       = mv_q;
        tour_go    = 1'b0;
        ext_rdy    = 1'b0;
        cmd        = '0;
        cmd_vld    = 1'b0;
        tour_cmplt = 1'b0;
        err        = 1'b0;
        case (state_q)
            S_IDLE: begin
                // start_tour takes the port; the coincident ext command stays pending
                if (!rst) begin
                    cmd     = ext_cmd;
                    cmd_vld = ext_vld & ~start_tour;
                    ext_rdy = cmd_rdy & ~start_tour;
                end
                if (start_tour) state_d = S_START;
            end
            S_START: begin
                tour_go  = 1'b1;
                to_cnt_d = '0;
                indx_d   = '0;
                state_d  = S_WAIT_SOLVE;
            end
            S_WAIT_SOLVE: begin
                if (tour_done) begin
                    state_d = S_FETCH;
                end else if (to_cnt_q == TO_W'(SOLVE_TO - 1)) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_FETCH: begin
                mv_d = move;
                if (!$onehot(move)) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LEG_V;
                end
            end
            S_LEG_V: begin
                cmd     = vcmd;
                cmd_vld = 1'b1;
                if (cmd_rdy) state_d = S_WAIT_V;
            end
            S_WAIT_V: begin
                if (cmd_cmplt) begin
                    if (pos_bad_v) begin
                        err     = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_LEG_H;
                    end
                end
            end
            S_LEG_H: begin
                cmd     = hcmd;
                cmd_vld = 1'b1;
                if (cmd_rdy) state_d = S_WAIT_H;
            end
            S_WAIT_H: begin
                if (cmd_cmplt) begin
                    if (pos_bad_h) begin
                        err     = 1'b1;
                        state_d = S_IDLE;
                    end else if (indx_q == 5'(NUM_MOVES - 1)) begin
                        tour_cmplt = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        indx_d  = indx_q + 5'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            to_cnt_q <= '0;
            indx_q   <= '0;
            mv_q     <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            indx_q   <= indx_d;
            mv_q     <= mv_d;
        end
    end

    assign indx = indx_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_tour_seq.sv
// Bench for tour_seq: idle pass-through vector table, solver/command-processor
// responders, and a move-table reference model for every issued leg.
module tb_tour_seq;
    localparam int NM = 24;
    localparam int DXS [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
    localparam int DYS [8] = '{ 2, 2,  1, -1, -2, -2, -1, 1};

    logic        clk = 1'b0, rst = 1'b1, start_tour = 1'b0;
    logic [2:0]  x_start = '0, y_start = '0;
    logic        tour_go, tour_done = 1'b0;
    logic [4:0]  indx;
    logic [7:0]  move;
    logic [15:0] ext_cmd = '0;
    logic        ext_vld = 1'b0, ext_rdy;
    logic [15:0] cmd;
    logic        cmd_vld, cmd_rdy, cmd_cmplt = 1'b0, busy, tour_cmplt, err;
`ifdef TOUR_SEQ_POS_EN
    logic [2:0]  cur_x, cur_y;
`endif
    logic        env_auto = 1'b0, rdy_auto = 1'b0, rdy_man = 1'b0;
    logic [7:0]  mvtab [NM];

    assign cmd_rdy = env_auto ? rdy_auto : rdy_man;
    assign move    = (indx < 5'(NM)) ? mvtab[indx] : 8'h00;

    tour_seq #(.NUM_MOVES(NM), .SOLVE_TO(1000), .TO_W(11)) dut (
        .clk(clk), .rst(rst), .start_tour(start_tour), .x_start(x_start), .y_start(y_start),
        .tour_go(tour_go), .tour_done(tour_done), .indx(indx), .move(move),
        .ext_cmd(ext_cmd), .ext_vld(ext_vld), .ext_rdy(ext_rdy),
        .cmd(cmd), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_cmplt(cmd_cmplt),
        .busy(busy), .tour_cmplt(tour_cmplt),
`ifdef TOUR_SEQ_POS_EN
        .cur_x(cur_x), .cur_y(cur_y),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int solve_dly = 100, rdy_dly = 0, cmplt_dly = 1;
    int cyc = 0, hs_n = 0, go_n = 0, cmplt_n = 0, err_n = 0, go_cyc = 0, err_cyc = 0;
    int b_hs, b_go, b_cm, b_err, b_q;
    logic [15:0] got_cmd [$];
    logic [4:0]  got_idx [$];

    typedef struct {
        logic [15:0] ext_cmd; logic ext_vld; logic rdy; logic start;
        logic [15:0] e_cmd;   logic e_vld;   logic e_rdy; logic e_busy;
    } vec_t;
    vec_t vt [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // Expected leg straight from the move rules: one-hot bit -> (dx,dy) -> command word
    function automatic logic [15:0] leg(input logic [7:0] mv, input bit horiz);
        int b, d, mag;
        b = 0;
        for (int i = 0; i < 8; i++) if (mv[i]) b = i;
        d   = horiz ? DXS[b] : DYS[b];
        mag = (d < 0) ? -d : d;
        if (horiz) return {4'h3, ((d > 0) ? 8'hBF : 8'h3F), 4'(mag)};
        return {4'h2, ((d > 0) ? 8'h00 : 8'h7F), 4'(mag)};
    endfunction

    // Responders: sample at negedge, drive just after posedge
    initial begin : env
        logic nd, nc, nr, stall;
        logic [15:0] prev_cmd;
        int solve_cnt, cmplt_cnt, wait_cnt;
        solve_cnt = 0; cmplt_cnt = 0; wait_cnt = 0; stall = 1'b0; prev_cmd = '0;
        forever begin
            @(negedge clk);
            cyc++;
            nd = 1'b0; nc = 1'b0; nr = (rdy_dly == 0);
            if (rst) begin
                solve_cnt = 0; cmplt_cnt = 0; wait_cnt = 0; stall = 1'b0;
            end else begin
                if (tour_go) begin go_n++; go_cyc = cyc; if (solve_dly > 0) solve_cnt = solve_dly; end
                if (err) begin err_n++; err_cyc = cyc; end
                if (tour_cmplt) cmplt_n++;
                if (busy) chk("busy_ext_rdy", ext_rdy, 0);
                if (busy && cmd_vld) begin
                    if (stall) chk("cmd_stable", cmd, prev_cmd);
                    if (cmd_rdy) begin
                        got_cmd.push_back(cmd); got_idx.push_back(indx); hs_n++;
                        stall = 1'b0; wait_cnt = 0; cmplt_cnt = cmplt_dly;
                    end else begin
                        stall = 1'b1; prev_cmd = cmd; wait_cnt++;
                        if (wait_cnt >= rdy_dly) nr = 1'b1;
                    end
                end else begin
                    stall = 1'b0; wait_cnt = 0;
                end
                if (solve_cnt > 0) begin solve_cnt--; if (solve_cnt == 0) nd = 1'b1; end
                if (cmplt_cnt > 0) begin cmplt_cnt--; if (cmplt_cnt == 0) nc = 1'b1; end
            end
            @(posedge clk); #1;
            tour_done = nd; cmd_cmplt = nc; rdy_auto = nr;
        end
    end

    task automatic tick(); @(negedge clk); #1; endtask

    task automatic snap();
        b_hs = hs_n; b_go = go_n; b_cm = cmplt_n; b_err = err_n; b_q = got_cmd.size();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        tick();
        while (busy && n < budget) begin tick(); n++; end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n;
        n = 0;
        while (hs_n < target && n < budget) begin tick(); n++; end
        chk("hs_timeout", (hs_n >= target), 1);
    endtask

    task automatic run_tour(input logic [2:0] x, input logic [2:0] y,
                            input int sd, input int rd, input int cd, input int budget);
        @(posedge clk); #1;
        x_start = x; y_start = y; solve_dly = sd; rdy_dly = rd; cmplt_dly = cd; env_auto = 1'b1;
        snap();
        start_tour = 1'b1;
        @(posedge clk); #1;
        start_tour = 1'b0;
        wait_idle(budget);
    endtask

    task automatic check_tour();
        chk("hs_count", got_cmd.size() - b_q, 2 * NM);
        for (int k = 0; k < 2 * NM && b_q + k < got_cmd.size(); k++) begin
            chk($sformatf("leg%0d_cmd", k), got_cmd[b_q + k], leg(mvtab[k / 2], (k % 2) == 1));
            chk($sformatf("leg%0d_indx", k), got_idx[b_q + k], k / 2);
        end
        chk("tour_cmplt_pulses", cmplt_n - b_cm, 1);
        chk("tour_go_pulses", go_n - b_go, 1);
        chk("tour_err", err_n - b_err, 0);
    endtask

    task automatic check_passthru(input string nm);
        @(posedge clk); #1;
        env_auto = 1'b0; rdy_man = 1'b1; ext_cmd = 16'h2003; ext_vld = 1'b1;
        tick();
        chk({nm, "_cmd"}, cmd, 16'h2003);
        chk({nm, "_vld"}, cmd_vld, 1);
        chk({nm, "_rdy"}, ext_rdy, 1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NM; i++) mvtab[i] = 8'(1 << $urandom_range(0, 7));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        vt[0] = '{16'h2003, 1'b1, 1'b1, 1'b0, 16'h2003, 1'b1, 1'b1, 1'b0};
        vt[1] = '{16'h2003, 1'b1, 1'b0, 1'b0, 16'h2003, 1'b1, 1'b0, 1'b0};
        vt[2] = '{16'h3BF1, 1'b0, 1'b1, 1'b0, 16'h3BF1, 1'b0, 1'b1, 1'b0};
        vt[3] = '{16'hFFFF, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0};
        vt[4] = '{16'h1234, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < NM; i++) mvtab[i] = 8'h02;
        mvtab[5] = 8'h08;

        // Reset state with live external traffic on the port
        rst = 1'b1; ext_cmd = 16'hA5A5; ext_vld = 1'b1; rdy_man = 1'b1;
        repeat (3) @(posedge clk);
        tick();
        chk("rst_cmd", cmd, 0);          chk("rst_cmd_vld", cmd_vld, 0);
        chk("rst_ext_rdy", ext_rdy, 0);  chk("rst_busy", busy, 0);
        chk("rst_tour_go", tour_go, 0);  chk("rst_indx", indx, 0);
        chk("rst_err", err, 0);          chk("rst_tour_cmplt", tour_cmplt, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle pass-through table; last vector starts the test-plan tour from (2,2)
        x_start = 3'd2; y_start = 3'd2; solve_dly = 100; rdy_dly = 0; cmplt_dly = 1;
        snap();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            ext_cmd = vt[i].ext_cmd; ext_vld = vt[i].ext_vld; rdy_man = vt[i].rdy; start_tour = vt[i].start;
            tick();
            chk($sformatf("vec%0d_cmd", i), cmd, vt[i].e_cmd);
            chk($sformatf("vec%0d_vld", i), cmd_vld, vt[i].e_vld);
            chk($sformatf("vec%0d_rdy", i), ext_rdy, vt[i].e_rdy);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
        end
        @(posedge clk); #1;
        start_tour = 1'b0; env_auto = 1'b1; ext_cmd = 16'h2003; ext_vld = 1'b1;
        tick();
        chk("start_tour_go", tour_go, 1);
        chk("start_busy", busy, 1);
        tick();
        chk("solve_tour_go_low", tour_go, 0);
        chk("solve_cmd_vld", cmd_vld, 0);
        wait_idle(3000);
        check_tour();
        chk("tp_first_v", got_cmd[b_q + 0], 16'h2002);
        chk("tp_first_h", got_cmd[b_q + 1], 16'h3BF1);
        chk("tp_m5_v", got_cmd[b_q + 10], 16'h27F1);
        chk("tp_m5_h", got_cmd[b_q + 11], 16'h33F2);
        chk("tp_m5_h_indx", got_idx[b_q + 11], 5);
        chk("tp_m6_v_indx", got_idx[b_q + 12], 6);
        check_passthru("post_tour1");

        // Slow command processor: ready 3 cycles late on every leg
        fill_random();
        run_tour(3'd0, 3'd0, 20, 3, 2, 4000);
        check_tour();
        check_passthru("post_tour2");

        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_tour(3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)),
                     $urandom_range(1, 30), $urandom_range(0, 3), $urandom_range(1, 3), 4000);
            check_tour();
        end

        // Solver never answers
        run_tour(3'd1, 3'd1, 0, 0, 1, 1500);
        chk("to_err_pulses", err_n - b_err, 1);
        chk("to_err_cycle", err_cyc - go_cyc, 1000);
        chk("to_no_legs", hs_n - b_hs, 0);
        chk("to_no_cmplt", cmplt_n - b_cm, 0);

        // Non-one-hot moves
        mvtab[0] = 8'h03;
        run_tour(3'd1, 3'd1, 5, 0, 1, 200);
        chk("bad03_err", err_n - b_err, 1);
        chk("bad03_no_legs", hs_n - b_hs, 0);
        fill_random();
        mvtab[3] = 8'h00;
        run_tour(3'd1, 3'd1, 5, 0, 1, 500);
        chk("bad00_err", err_n - b_err, 1);
        chk("bad00_legs", hs_n - b_hs, 6);

        // start_tour while busy, then reset in WAIT_H
        fill_random();
        @(posedge clk); #1;
        solve_dly = 10; rdy_dly = 0; cmplt_dly = 3; env_auto = 1'b1;
        snap();
        start_tour = 1'b1;
        @(posedge clk); #1;
        start_tour = 1'b0;
        wait_hs(b_hs + 1, 500);
        @(posedge clk); #1;
        start_tour = 1'b1;
        @(posedge clk); #1;
        start_tour = 1'b0;
        tick();
        chk("busy_start_busy", busy, 1);
        chk("busy_start_go", go_n - b_go, 1);
        chk("busy_start_indx", indx, 0);
        wait_hs(b_hs + 4, 500);
        @(posedge clk); #1;
        chk("wait_h_busy", busy, 1);
        chk("wait_h_vld", cmd_vld, 0);
        chk("wait_h_indx", indx, 1);
        rst = 1'b1;
        @(posedge clk);
        tick();
        chk("midrst_busy", busy, 0);       chk("midrst_indx", indx, 0);
        chk("midrst_cmd", cmd, 0);         chk("midrst_cmd_vld", cmd_vld, 0);
        chk("midrst_ext_rdy", ext_rdy, 0); chk("midrst_tour_go", tour_go, 0);
        chk("midrst_err", err, 0);         chk("midrst_cmplt", tour_cmplt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (50) tick();
        chk("midrst_no_rekick", go_n - b_go, 1);
        chk("midrst_idle", busy, 0);
        chk("midrst_no_more_legs", hs_n - b_hs, 4);
        chk("midrst_no_tour_cmplt", cmplt_n - b_cm, 0);
        check_passthru("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
